// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data memory: control word, size codes,
// fault causes, FSM states and the load-extension helper.
package mem_pkg;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] size;
    logic       sign;      // 0 = sign-extend, 1 = zero-extend
  } mem_ctrl_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_ILLEGAL  = 2'b11
  } mem_fault_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_RESP    = 2'b10
  } mem_ram_state_e;

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] mem_extend(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size,
                                             input logic        sign);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: mem_extend = {{24{~sign & b[7]}}, b};
      SZ_HALF: mem_extend = {{16{~sign & h[15]}}, h};
      default: mem_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane_ram.sv
// DEPTH_WORDS x 32 array with per-byte write enables and a registered read
// port. No reset on purpose, so tools can map it onto block RAM.
module mem_byte_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 2048
) (
  input  logic                           clk,
  input  logic [3:0]                     i_be,
  input  logic                           i_re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) mem_q[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    if (i_re) rdata_q <= mem_q[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_data_ram.sv
// MEM-stage data memory: one outstanding request, configurable read latency,
// fault screening before any array access, byte-lane steering and extension.
module mem_data_ram
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned RD_LAT      = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_req_valid,
  output logic           o_req_ready,
  input  logic [31:0]    i_memAddr,
  input  logic [31:0]    i_writeData,
  input  mem_ctrl_t      i_ctrlMEM,
  output logic           o_rsp_valid,
  input  logic           i_rsp_ready,
  output logic [31:0]    o_readData,
  output logic           o_fault,
  output logic [1:0]     o_fault_cause,
  output mem_ram_state_e o_dbg_state
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  LAT_INIT = 2'(RD_LAT - 1);

  // Handshakes: a request transfers on a cycle with i_req_valid & o_req_ready,
  // a response on o_rsp_valid & i_rsp_ready; the response side holds its
  // payload stable while valid is high and not yet accepted.

  mem_ram_state_e state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [1:0]     lane_q, lane_d;
  logic [1:0]     size_q, size_d;
  logic           sign_q, sign_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           fault_q, fault_d;
  mem_fault_e     cause_q, cause_d;

  logic [31:0]    off;
  logic           access, illegal, misalign, out_of_range;
  mem_fault_e     fault_now;
  logic [3:0]     st_be;
  logic [31:0]    st_wdata;
  logic [3:0]     ram_be;
  logic           ram_re;
  logic [31:0]    ram_rdata;

  // Offset from the window base; the base is aligned so its low bits equal the address's.
  assign off = i_memAddr - BASE_ADDR;

  always_comb begin
    access       = i_ctrlMEM.memRead | i_ctrlMEM.memWrite;
    illegal      = (i_ctrlMEM.memRead & i_ctrlMEM.memWrite) |
                   ((i_ctrlMEM.size == 2'b11) & access);
    misalign     = access & (((i_ctrlMEM.size == SZ_HALF) & off[0]) |
                             ((i_ctrlMEM.size == SZ_WORD) & (off[1:0] != 2'b00)));
    out_of_range = access & (off[31:AW+2] != '0);
    if (illegal)           fault_now = FAULT_ILLEGAL;
    else if (misalign)     fault_now = FAULT_MISALIGN;
    else if (out_of_range) fault_now = FAULT_RANGE;
    else                   fault_now = FAULT_NONE;
  end

  // Narrow store data is replicated across lanes; the enables pick the lane(s).
  always_comb begin
    case (i_ctrlMEM.size)
      SZ_BYTE: begin
        st_wdata = {4{i_writeData[7:0]}};
        st_be    = 4'b0001 << off[1:0];
      end
      SZ_HALF: begin
        st_wdata = {2{i_writeData[15:0]}};
        st_be    = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = i_writeData;
        st_be    = 4'b1111;
      end
    endcase
  end

  mem_byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (i_clk),
    .i_be    (ram_be),
    .i_re    (ram_re),
    .i_addr  (off[AW+1:2]),
    .i_wdata (st_wdata),
    .o_rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    size_d     = size_q;
    sign_d     = sign_q;
    rsp_data_d = rsp_data_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    ram_be     = 4'b0000;
    ram_re     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          lane_d     = off[1:0];
          size_d     = i_ctrlMEM.size;
          sign_d     = i_ctrlMEM.sign;
          rsp_data_d = '0;
          cause_d    = fault_now;
          fault_d    = (fault_now != FAULT_NONE);
          if (fault_now != FAULT_NONE) begin
            state_d = ST_RESP;
          end else if (i_ctrlMEM.memWrite) begin
            ram_be  = st_be;
            state_d = ST_RESP;
          end else if (i_ctrlMEM.memRead) begin
            ram_re  = 1'b1;
            cnt_d   = LAT_INIT;
            state_d = ST_RD_WAIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_data_d = mem_extend(ram_rdata, lane_q, size_q, sign_q);
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_data_d = '0;
          fault_d    = 1'b0;
          cause_d    = FAULT_NONE;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      lane_q     <= 2'd0;
      size_q     <= 2'd0;
      sign_q     <= 1'b0;
      rsp_data_q <= '0;
      fault_q    <= 1'b0;
      cause_q    <= FAULT_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      rsp_data_q <= rsp_data_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
    end
  end

  assign o_req_ready   = (state_q == ST_IDLE);
  assign o_rsp_valid   = (state_q == ST_RESP);
  assign o_readData    = rsp_data_q;
  assign o_fault       = fault_q;
  assign o_fault_cause = cause_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_mem_data_ram.sv
// Bench for mem_data_ram: directed steps on an RD_LAT=3 instance, then random
// traffic on RD_LAT=1 and RD_LAT=4 instances against a byte-level model.
module tb_mem_data_ram;
  import mem_pkg::*;

  localparam logic [31:0] RB = 32'h0001_0000;  // base of the random-test instances

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  mem_ctrl_t   ctrl = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  wire  [2:0]  rdy_v, vld_v, flt_v;
  wire  [31:0] rd_v [3];
  wire  [1:0]  cz_v [3];
  wire  [1:0]  st_v [3];

  logic        rdy_s, vld_s, flt_s;
  logic [31:0] rd_s;
  logic [1:0]  cz_s, st_s;

  always_comb begin
    rdy_s = rdy_v[sel];
    vld_s = vld_v[sel];
    flt_s = flt_v[sel];
    rd_s  = rd_v[sel];
    cz_s  = cz_v[sel];
    st_s  = st_v[sel];
  end

  mem_data_ram #(.DEPTH_WORDS(2048), .RD_LAT(3), .BASE_ADDR(32'h0)) u_lat3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid && sel == 0),
    .o_req_ready(rdy_v[0]), .i_memAddr(addr), .i_writeData(wdata), .i_ctrlMEM(ctrl),
    .o_rsp_valid(vld_v[0]), .i_rsp_ready(rsp_ready), .o_readData(rd_v[0]),
    .o_fault(flt_v[0]), .o_fault_cause(cz_v[0]), .o_dbg_state(st_v[0]));

  mem_data_ram #(.DEPTH_WORDS(256), .RD_LAT(1), .BASE_ADDR(RB)) u_lat1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid && sel == 1),
    .o_req_ready(rdy_v[1]), .i_memAddr(addr), .i_writeData(wdata), .i_ctrlMEM(ctrl),
    .o_rsp_valid(vld_v[1]), .i_rsp_ready(rsp_ready), .o_readData(rd_v[1]),
    .o_fault(flt_v[1]), .o_fault_cause(cz_v[1]), .o_dbg_state(st_v[1]));

  mem_data_ram #(.DEPTH_WORDS(256), .RD_LAT(4), .BASE_ADDR(RB)) u_lat4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid && sel == 2),
    .o_req_ready(rdy_v[2]), .i_memAddr(addr), .i_writeData(wdata), .i_ctrlMEM(ctrl),
    .o_rsp_valid(vld_v[2]), .i_rsp_ready(rsp_ready), .o_readData(rd_v[2]),
    .o_fault(flt_v[2]), .o_fault_cause(cz_v[2]), .o_dbg_state(st_v[2]));

  int tests = 0;
  int fails = 0;

  // Byte-addressed reference memory, keyed by instance and offset from base.
  logic [7:0]  mdl [int];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic mem_ctrl_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                                   input logic sg);
    mem_ctrl_t c;
    c.memRead  = rd;
    c.memWrite = wr;
    c.size     = sz;
    c.sign     = sg;
    return c;
  endfunction

  function automatic int key(input int s, input logic [31:0] off);
    return s * 4096 + int'(off);
  endfunction

  function automatic logic [31:0] model_load(input int s, input logic [31:0] off,
                                             input int nb, input logic sg);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(mdl[key(s, off) + i]) << (8 * i));
    if (nb < 4 && !sg && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  task automatic model_store(input int s, input logic [31:0] off, input int nb,
                             input logic [31:0] d);
    for (int i = 0; i < nb; i++) mdl[key(s, off) + i] = d[8*i +: 8];
  endtask

  // lat = clock edges from the acceptance edge until o_rsp_valid is seen.
  task automatic issue(input mem_ctrl_t c, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic f,
                       output logic [1:0] cz);
    int n;
    n = 0;
    ctrl = c; addr = a; wdata = wd; req_valid = 1'b1;
    while (!rdy_s && n < 20) begin @(posedge clk); #1; n++; end
    check("accept_ready", 32'(rdy_s), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ctrl = mem_ctrl_t'(5'($urandom)); addr = $urandom; wdata = $urandom;
    lat = 0;
    while (!vld_s && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rd_s; f = flt_s; cz = cz_s;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input mem_ctrl_t c, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] e_data, input logic e_f,
                      input logic [1:0] e_cz, input int e_lat);
    int          lat;
    logic [31:0] rd;
    logic        f;
    logic [1:0]  cz;
    issue(c, a, wd, lat, rd, f, cz);
    check({tag, "_lat"},   32'(lat), 32'(e_lat));
    check({tag, "_data"},  rd, e_data);
    check({tag, "_fault"}, 32'(f), 32'(e_f));
    check({tag, "_cause"}, 32'(cz), 32'(e_cz));
  endtask

  initial begin
    int          nb, lat_ld, wait_n;
    logic [31:0] off, d, e;
    logic [1:0]  sz;
    logic        is_ld, sg, oor, seen;

    // Reset values
    #1;
    check("rst_rsp_valid", 32'(vld_s), 32'd0);
    check("rst_req_ready", 32'(rdy_s), 32'd1);
    check("rst_read_data", rd_s, 32'd0);
    check("rst_fault", 32'(flt_s), 32'd0);
    check("rst_cause", 32'(cz_s), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // RD_LAT=3 store/load word
    xact("st_word",  mk(0, 1, SZ_WORD, 0), 32'h100, 32'hDEADBEEF, 32'h0, 0, 2'b00, 0);
    xact("ld_word",  mk(1, 0, SZ_WORD, 0), 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'b00, 3);

    // Lane steering and extension
    xact("st_base",  mk(0, 1, SZ_WORD, 0), 32'h200, 32'h11223344, 32'h0, 0, 2'b00, 0);
    xact("st_byte",  mk(0, 1, SZ_BYTE, 0), 32'h203, 32'hABCDEF80, 32'h0, 0, 2'b00, 0);
    xact("ld_merge", mk(1, 0, SZ_WORD, 1), 32'h200, 32'h0, 32'h80223344, 0, 2'b00, 3);
    xact("ld_bs",    mk(1, 0, SZ_BYTE, 0), 32'h203, 32'h0, 32'hFFFFFF80, 0, 2'b00, 3);
    xact("ld_bu",    mk(1, 0, SZ_BYTE, 1), 32'h203, 32'h0, 32'h00000080, 0, 2'b00, 3);
    xact("ld_hs",    mk(1, 0, SZ_HALF, 0), 32'h202, 32'h0, 32'hFFFF8022, 0, 2'b00, 3);
    xact("ld_hu_lo", mk(1, 0, SZ_HALF, 1), 32'h200, 32'h0, 32'h00003344, 0, 2'b00, 3);

    // Faults and range boundary
    xact("st_misal", mk(0, 1, SZ_HALF, 0), 32'h101, 32'h0000FFFF, 32'h0, 1, 2'b01, 0);
    xact("ld_after_misal", mk(1, 0, SZ_WORD, 0), 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'b00, 3);
    xact("ld_oor",   mk(1, 0, SZ_WORD, 0), 32'h2000, 32'h0, 32'h0, 1, 2'b10, 0);
    xact("st_last",  mk(0, 1, SZ_WORD, 0), 32'h1FFC, 32'hCAFEF00D, 32'h0, 0, 2'b00, 0);
    xact("ld_last",  mk(1, 0, SZ_WORD, 0), 32'h1FFC, 32'h0, 32'hCAFEF00D, 0, 2'b00, 3);
    xact("rw_both",  mk(1, 1, SZ_WORD, 0), 32'h100, 32'h0, 32'h0, 1, 2'b11, 0);
    xact("size_11",  mk(1, 0, 2'b11, 0),   32'h100, 32'h0, 32'h0, 1, 2'b11, 0);
    xact("ld_misal_w", mk(1, 0, SZ_WORD, 0), 32'h102, 32'h0, 32'h0, 1, 2'b01, 0);
    xact("noop",     mk(0, 0, SZ_WORD, 0), 32'h101, 32'h0, 32'h0, 0, 2'b00, 0);

    // Backpressure: response held, stall-time request ignored
    ctrl = mk(1, 0, SZ_WORD, 0); addr = 32'h200; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_n = 0;
    while (!vld_s && wait_n < 20) begin @(posedge clk); #1; wait_n++; end
    check("bp_lat", 32'(wait_n), 32'd3);
    ctrl = mk(0, 1, SZ_WORD, 0); addr = 32'h200; wdata = 32'h55555555; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(vld_s), 32'd1);
      check("bp_data", rd_s, 32'h80223344);
      check("bp_fault", 32'(flt_s), 32'd0);
      check("bp_ready", 32'(rdy_s), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_done_valid", 32'(vld_s), 32'd0);
    check("bp_done_ready", 32'(rdy_s), 32'd1);
    xact("bp_ld_after", mk(1, 0, SZ_WORD, 0), 32'h200, 32'h0, 32'h80223344, 0, 2'b00, 3);

    // Reset while a read is in flight
    ctrl = mk(1, 0, SZ_WORD, 0); addr = 32'h100; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_state", 32'(st_s), 32'(ST_RD_WAIT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(vld_s), 32'd0);
    check("mid_rst_data", rd_s, 32'd0);
    check("mid_rst_fault", 32'(flt_s), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rel_ready", 32'(rdy_s), 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (vld_s) seen = 1'b1;
    end
    check("mid_no_stale", 32'(seen), 32'd0);
    xact("mid_mem_kept", mk(1, 0, SZ_WORD, 0), 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'b00, 3);

    // Random sweep on RD_LAT=1 and RD_LAT=4 against the byte model
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      lat_ld = (s == 1) ? 1 : 4;
      for (int w = 0; w < 64; w++) begin
        d = $urandom;
        off = 32'(w * 4);
        model_store(s, off, 4, d);
        xact("init", mk(0, 1, SZ_WORD, 0), RB + off, d, 32'h0, 0, 2'b00, 0);
      end
      for (int k = 0; k < 100; k++) begin
        sz    = 2'($urandom_range(0, 2));
        nb    = 1 << sz;
        is_ld = 1'($urandom_range(0, 1));
        sg    = 1'($urandom_range(0, 1));
        d     = $urandom;
        case ($urandom_range(0, 9))
          0:       off = 32'd1024 + 32'(nb * $urandom_range(0, 15));
          1:       off = 32'hFFFF_FFFC;
          default: off = 32'(nb * $urandom_range(0, 256 / nb - 1));
        endcase
        oor = (off >= 32'd1024);
        if (is_ld && !oor) exp_q.push_back(model_load(s, off, nb, sg));
        else               exp_q.push_back(32'h0);
        if (!is_ld && !oor) model_store(s, off, nb, d);
        e = exp_q.pop_front();
        xact(is_ld ? "rnd_ld" : "rnd_st", mk(is_ld, !is_ld, sz, sg), RB + off, d, e,
             oor, oor ? 2'b10 : 2'b00, (is_ld && !oor) ? lat_ld : 0);
      end
      for (int w = 0; w < 64; w += 7) begin
        off = 32'(w * 4);
        xact("final_ld", mk(1, 0, SZ_WORD, 0), RB + off, 32'h0, model_load(s, off, 4, 1'b0),
             0, 2'b00, lat_ld);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_data_ram.md
Name: mem_data_ram

Overview:
- Parametrised data memory for the MEM stage. Successor to the fixed 2048-word, zero-latency array.
- Adds a configurable depth and a base address.
- Adds a configurable read latency with a valid/ready request/response handshake.
- Adds fault reporting for misaligned, out-of-range and illegal accesses.
- Sits between the MEM-stage control (mem_ctrl_t) and the MEM/WB pipeline register. The pipeline stalls on o_req_ready / o_rsp_valid.

Parameters:
- DEPTH_WORDS, 2048, number of 32-bit words; power of two, 16..65536.
- RD_LAT, 1, cycles from read acceptance to o_rsp_valid; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  block can accept a request this cycle.
- i_memAddr  input  32  byte address.
- i_writeData  input  32  store data; the low byte or halfword is used for narrow stores.
- i_ctrlMEM  input  mem_ctrl_t  fields memRead, memWrite, size[1:0] (00 byte, 01 half, 10 word), sign (0 = sign-extend, 1 = zero-extend).
- o_rsp_valid  output  1  response present.
- i_rsp_ready  input  1  consumer accepts the response.
- o_readData  output  32  extended load data; 0 for stores and faults.
- o_fault  output  1  qualifies o_rsp_valid: the access was rejected.
- o_fault_cause  output  2  fault code: 00 none, 01 misaligned, 10 out of range, 11 illegal control.

Behaviour:
- Reset (async, i_reset_n low):
  - FSM goes to IDLE.
  - o_rsp_valid=0, o_readData=0, o_fault=0, o_fault_cause=0, o_req_ready=1 after reset.
  - Latency counter is cleared.
  - Memory contents are NOT reset, so the array is RAM-inferable. Contents are undefined until written.
  - Reset mid-operation abandons the in-flight access. A store accepted in the same cycle as reset assertion is not guaranteed.
- One outstanding request. A request is accepted when i_req_valid & o_req_ready. o_req_ready = (state==IDLE).
- Request fields are captured on acceptance. Later input changes have no effect on that access.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE, accepted request with a fault -> RESP with o_fault=1. No array access.
  - IDLE, accepted store -> array write in the acceptance cycle -> RESP. o_rsp_valid is asserted the next cycle with o_readData=0.
  - IDLE, accepted load -> RD_WAIT with counter=RD_LAT-1.
  - RD_WAIT decrements the counter. When the counter reaches 0 -> RESP.
  - Load data timing: o_rsp_valid asserts exactly RD_LAT cycles after the acceptance edge.
  - RESP holds o_rsp_valid, o_readData, o_fault and o_fault_cause stable until i_rsp_ready. The handshake cycle returns to IDLE.
  - No same-cycle back-to-back: the next request can be accepted the cycle after the response handshake.
  - A request with memRead=0 and memWrite=0 is accepted and completes as a no-op response (readData 0, no fault).
- Fault checks, in priority order:
  1. Illegal control (cause 11): memRead & memWrite both set, or size==11 with either memRead or memWrite set.
  2. Misaligned (cause 01): half with addr[0]=1; word with addr[1:0]!=0.
  3. Out of range (cause 10): (addr - BASE_ADDR) >= DEPTH_WORDS*4, computed as a 32-bit unsigned subtraction.
- A faulting store never modifies the array.
- Word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Stores use per-lane byte enables:
  - byte: lane addr[1:0];
  - half: lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes.
  - Bytes outside the enabled lanes are unchanged.
- Loads select the lane(s) by addr[1:0] / addr[1], then extend per the sign field. Word loads ignore sign.
- Little-endian byte order: byte 0 = bits [7:0].

Decomposition:
- Shared package (mem_pkg):
  - mem_ctrl_t;
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD;
  - fault cause enum mem_fault_e;
  - state enum mem_ram_state_e.
- One sub-module, mem_byte_lane_ram: a DEPTH_WORDS x 32 array with a 4-bit byte-write enable and a registered read port. It holds no reset logic, so it is RAM-inferable.
- The FSM, latency counter, fault check, lane steering and extension stay in mem_data_ram.

Test Plan:
1. RD_LAT=3: store word 0xDEADBEEF at 0x100, then load word at 0x100 -> o_rsp_valid exactly 3 cycles after acceptance, readData 0xDEADBEEF, fault 0.
2. Lane steering and extension:
   - Store byte 0x80 at 0x203 over word 0x11223344 -> word reads 0x80223344.
   - Load byte signed from 0x203 -> 0xFFFFFF80.
   - Load byte unsigned from 0x203 -> 0x00000080.
   - Load half signed from 0x202 -> 0xFFFF8022.
3. Faults:
   - Store half at 0x101 -> fault, cause 01; the word at 0x100 is unchanged.
   - Load at BASE_ADDR + DEPTH_WORDS*4 -> cause 10.
   - memRead and memWrite both set -> cause 11.
4. Backpressure: hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid, data and o_fault stable, o_req_ready=0. A new i_req_valid during the stall is not accepted; its store has no effect.
5. Reset mid-read: assert i_reset_n=0 in RD_WAIT -> outputs 0 immediately (async), o_req_ready=1 after release, no stale response ever appears.
6. Sweep RD_LAT=1 and RD_LAT=4 with 100 random aligned accesses against a reference model -> all responses match and latency equals RD_LAT.
